// File: rtl/lock_controller.sv
// rtl/lock_controller.sv - keypad lock front end: key conditioning, sequencing FSM, checker strobes
// Debounced key presses drive a program/lock/compare FSM that strobes the downstream code checker.
module lock_controller #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int MAX_LEN         = 4,
  parameter int MAX_ATTEMPTS    = 3,
  parameter int STROBE_CYCLES   = 2,
  parameter int RST_CYCLES      = 4
) (
  input  logic       clk,
  input  logic       system_reset,
  input  logic [3:0] digit_key_n,
  input  logic       enter_key_n,
  input  logic       program_sw,
  input  logic       correct_password,
  input  logic       incorrect_password,
  output logic [1:0] bits,
  output logic       store_value,
  output logic       input_value,
  output logic       compare,
  output logic       input_reset,
  output logic       checker_reset,
  output logic       unlocked,
  output logic       alarm,
  output logic [2:0] state,
  output logic [2:0] digit_count
);

  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TW  = $clog2(STROBE_CYCLES + 2);
  localparam int CW  = $clog2(STROBE_CYCLES + 5);
  localparam int RW  = $clog2(RST_CYCLES + 1);
  localparam int AW  = $clog2(MAX_ATTEMPTS + 1);

  localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0]  T_START  = TW'(STROBE_CYCLES + 1);
  localparam logic [CW-1:0]  C_HIGH   = CW'(STROBE_CYCLES);
  localparam logic [CW-1:0]  C_SAMPLE = CW'(STROBE_CYCLES + 4);
  localparam logic [RW-1:0]  R_INIT   = RW'(RST_CYCLES);
  localparam logic [RW-1:0]  R_LAST   = RW'(RST_CYCLES - 1);
  localparam logic [AW-1:0]  ATT_MAX  = AW'(MAX_ATTEMPTS);
  localparam logic [2:0]     LEN_MAX  = 3'(MAX_LEN);

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_PROGRAM = 3'd1,
    S_LOCKED  = 3'd2,
    S_COMPARE = 3'd3,
    S_OPEN    = 3'd4,
    S_FAIL    = 3'd5,
    S_ALARM   = 3'd6
  } state_t;

  // Key vector bit 4 is enter, bits 3:0 are digits; all active-low until press_q.
  logic [4:0]     sync1_q, sync2_q, deb_q, deb_d, press_q, press_d;
  logic [DBW-1:0] db_cnt_q [5];
  logic [DBW-1:0] db_cnt_d [5];

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [AW-1:0] att_q, att_d, att_inc;
  logic [1:0]    bits_q, bits_d, dig_val;
  logic          kind_q, kind_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [CW-1:0] ctm_q, ctm_d;
  logic [RW-1:0] rtm_q, rtm_d;
  logic          cr_q, cr_d, ir_q, ir_d;
  logic          store_q, store_d, input_q, input_d, compare_q, compare_d;
  logic          unlocked_q, unlocked_d, alarm_q, alarm_d;
  logic          dig_ev, ent_ev, busy;

  // Incorrect and no-answer take the same path, so only correct_password is decoded.
  logic unused_incorrect;
  assign unused_incorrect = incorrect_password;

  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 5; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) deb_d[i] = sync2_q[i];
        else                        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
    press_d = deb_q & ~deb_d;
  end

  always_comb begin
    dig_val = 2'd3;
    for (int i = 3; i >= 0; i--) begin
      if (press_q[i]) dig_val = 2'(i);
    end
    dig_ev = |press_q[3:0];
    ent_ev = press_q[4] & ~dig_ev;
    busy   = (tmr_q != '0) || (state_q == S_COMPARE) || (state_q == S_INIT) || !cr_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    att_d   = att_q;
    att_inc = (att_q == ATT_MAX) ? att_q : att_q + 1'b1;
    bits_d  = bits_q;
    kind_d  = kind_q;
    tmr_d   = (tmr_q != '0) ? tmr_q - 1'b1 : '0;
    ctm_d   = ctm_q;
    rtm_d   = rtm_q;
    cr_d    = cr_q;
    ir_d    = 1'b1;

    if (!cr_q) begin
      if (rtm_q != '0) rtm_d = rtm_q - 1'b1;
      else             cr_d  = 1'b1;
    end

    case (state_q)
      S_INIT: begin
        if (rtm_q == '0) state_d = S_PROGRAM;
        else             ir_d    = 1'b0;
      end
      S_PROGRAM: begin
        if (!busy && dig_ev && cnt_q < LEN_MAX) begin
          bits_d = dig_val;
          kind_d = 1'b0;
          tmr_d  = T_START;
          cnt_d  = cnt_q + 1'b1;
        end else if (!busy && ent_ev && cnt_q != 3'd0) begin
          ir_d    = 1'b0;
          cnt_d   = 3'd0;
          state_d = S_LOCKED;
        end
      end
      S_LOCKED: begin
        if (!busy && dig_ev) begin
          if (cnt_q < LEN_MAX) begin
            bits_d = dig_val;
            kind_d = 1'b1;
            tmr_d  = T_START;
            cnt_d  = cnt_q + 1'b1;
          end
        end else if (!busy && ent_ev) begin
          ctm_d   = CW'(1);
          state_d = S_COMPARE;
        end
      end
      S_COMPARE: begin
        ctm_d = ctm_q + 1'b1;
        if (ctm_q == C_SAMPLE) begin
          ctm_d = '0;
          cnt_d = 3'd0;
          if (correct_password) begin
            att_d   = '0;
            state_d = S_OPEN;
          end else begin
            att_d   = att_inc;
            state_d = (att_inc == ATT_MAX) ? S_ALARM : S_FAIL;
          end
        end
      end
      S_OPEN: begin
        if (!busy && ent_ev) begin
          cnt_d = 3'd0;
          if (program_sw) begin
            cr_d    = 1'b0;
            rtm_d   = R_LAST;
            state_d = S_PROGRAM;
          end else begin
            ir_d    = 1'b0;
            state_d = S_LOCKED;
          end
        end
      end
      S_FAIL: begin
        if (!busy && ent_ev) begin
          ir_d    = 1'b0;
          state_d = S_LOCKED;
        end
      end
      S_ALARM: state_d = S_ALARM;
      default: state_d = S_INIT;
    endcase

    // A strobe is high for the STROBE_CYCLES cycles that follow the bits update.
    store_d    = (tmr_q > TW'(1)) && !kind_q;
    input_d    = (tmr_q > TW'(1)) && kind_q;
    compare_d  = (state_q == S_COMPARE) && (ctm_q != '0) && (ctm_q <= C_HIGH);
    unlocked_d = (state_d == S_OPEN);
    alarm_d    = (state_d == S_ALARM);
  end

  always_ff @(posedge clk or negedge system_reset) begin
    if (!system_reset) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      deb_q      <= '1;
      press_q    <= '0;
      for (int i = 0; i < 5; i++) db_cnt_q[i] <= '0;
      state_q    <= S_INIT;
      cnt_q      <= 3'd0;
      att_q      <= '0;
      bits_q     <= 2'd0;
      kind_q     <= 1'b0;
      tmr_q      <= '0;
      ctm_q      <= '0;
      rtm_q      <= R_INIT;
      cr_q       <= 1'b0;
      ir_q       <= 1'b0;
      store_q    <= 1'b0;
      input_q    <= 1'b0;
      compare_q  <= 1'b0;
      unlocked_q <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      sync1_q    <= {enter_key_n, digit_key_n};
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      press_q    <= press_d;
      for (int i = 0; i < 5; i++) db_cnt_q[i] <= db_cnt_d[i];
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      att_q      <= att_d;
      bits_q     <= bits_d;
      kind_q     <= kind_d;
      tmr_q      <= tmr_d;
      ctm_q      <= ctm_d;
      rtm_q      <= rtm_d;
      cr_q       <= cr_d;
      ir_q       <= ir_d;
      store_q    <= store_d;
      input_q    <= input_d;
      compare_q  <= compare_d;
      unlocked_q <= unlocked_d;
      alarm_q    <= alarm_d;
    end
  end

  assign bits          = bits_q;
  assign store_value   = store_q;
  assign input_value   = input_q;
  assign compare       = compare_q;
  assign input_reset   = ir_q;
  assign checker_reset = cr_q;
  assign unlocked      = unlocked_q;
  assign alarm         = alarm_q;
  assign state         = state_q;
  assign digit_count   = cnt_q;

endmodule

// File: tb/tb_lock_controller.sv
// tb/tb_lock_controller.sv - scoreboard bench for lock_controller
// Expected strobes are queued as keys are driven and matched when the DUT pulses them.
module tb_lock_controller;

  logic       clk = 1'b0;
  logic       system_reset;
  logic [3:0] digit_key_n;
  logic       enter_key_n;
  logic       program_sw;
  logic       correct_password;
  logic       incorrect_password;
  logic [1:0] bits;
  logic       store_value, input_value, compare;
  logic       input_reset, checker_reset, unlocked, alarm;
  logic [2:0] state, digit_count;

  lock_controller #(
    .DEBOUNCE_CYCLES(4), .MAX_LEN(4), .MAX_ATTEMPTS(3), .STROBE_CYCLES(2), .RST_CYCLES(4)
  ) dut (
    .clk(clk), .system_reset(system_reset), .digit_key_n(digit_key_n),
    .enter_key_n(enter_key_n), .program_sw(program_sw),
    .correct_password(correct_password), .incorrect_password(incorrect_password),
    .bits(bits), .store_value(store_value), .input_value(input_value), .compare(compare),
    .input_reset(input_reset), .checker_reset(checker_reset), .unlocked(unlocked),
    .alarm(alarm), .state(state), .digit_count(digit_count)
  );

  always #5 clk = ~clk;

  typedef struct {int kind; int val;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ir_low, cr_low;
  int   width [3];
  logic [2:0] cur, prev_str = 3'b0;
  logic [1:0] prev_bits = 2'd0;

  // Advance one cycle, sample at the falling edge and match strobe pulses against the queue.
  task automatic tick();
    @(negedge clk);
    if (!input_reset)   ir_low++;
    if (!checker_reset) cr_low++;
    cur = {compare, input_value, store_value};
    if (!system_reset) begin
      prev_str = 3'b0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (cur[k] && !prev_str[k]) begin
          n_checks++;
          width[k] = 1;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL strobe_unexpected kind=%0d bits=%0d", k, bits);
          end else begin
            e = exp_q.pop_front();
            if (e.kind != k || (k != 2 && (bits !== 2'(e.val) || prev_bits !== 2'(e.val)))) begin
              n_fail++;
              $display("FAIL strobe_match got kind=%0d bits=%0d prev_bits=%0d want kind=%0d bits=%0d",
                       k, bits, prev_bits, e.kind, e.val);
            end
          end
        end else if (cur[k]) begin
          width[k]++;
        end else if (prev_str[k]) begin
          n_checks++;
          if (width[k] != 2) begin
            n_fail++;
            $display("FAIL strobe_width kind=%0d got=%0d want=2", k, width[k]);
          end
        end
      end
      prev_str = cur;
    end
    prev_bits = bits;
  endtask

  // Press keys in mask (bit 4 = enter), optionally queueing the strobe it should produce.
  task automatic press(input logic [4:0] mask, input int kind, input int val);
    if (kind >= 0) exp_q.push_back('{kind, val});
    digit_key_n = ~mask[3:0];
    enter_key_n = ~mask[4];
    repeat (10) tick();
    digit_key_n = 4'hf;
    enter_key_n = 1'b1;
    repeat (12) tick();
  endtask

  task automatic test_reset();
    system_reset = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (state !== 3'd0 || bits !== 2'd0 || digit_count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state state=%0d bits=%0d count=%0d want 0", state, bits, digit_count);
    end
    n_checks++;
    if ({store_value, input_value, compare, unlocked, alarm} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b want=00000", {store_value, input_value, compare, unlocked, alarm});
    end
    n_checks++;
    if (input_reset !== 1'b0 || checker_reset !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_clears ir=%b cr=%b want 0 0", input_reset, checker_reset);
    end
    system_reset = 1'b1;
    ir_low = 0;
    cr_low = 0;
    repeat (10) tick();
    n_checks++;
    if (cr_low != 4 || ir_low != 4) begin
      n_fail++;
      $display("FAIL init_reset_len cr_low=%0d ir_low=%0d want 4 4", cr_low, ir_low);
    end
    n_checks++;
    if (state !== 3'd1) begin
      n_fail++;
      $display("FAIL init_state got=%0d want=1", state);
    end
  endtask

  task automatic test_program();
    press(5'b00100, 0, 2);
    press(5'b00010, 0, 1);
    press(5'b01000, 0, 3);
    n_checks++;
    if (digit_count !== 3'd3) begin
      n_fail++;
      $display("FAIL program_count got=%0d want=3", digit_count);
    end
    ir_low = 0;
    press(5'b10000, -1, 0);
    n_checks++;
    if (ir_low != 1 || state !== 3'd2 || digit_count !== 3'd0) begin
      n_fail++;
      $display("FAIL program_enter ir_low=%0d state=%0d count=%0d want 1 2 0", ir_low, state, digit_count);
    end
  endtask

  task automatic test_unlock();
    correct_password = 1'b1;
    incorrect_password = 1'b0;
    press(5'b00100, 1, 2);
    press(5'b00010, 1, 1);
    press(5'b01000, 1, 3);
    press(5'b10000, 2, 0);
    n_checks++;
    if (state !== 3'd4 || unlocked !== 1'b1 || digit_count !== 3'd0) begin
      n_fail++;
      $display("FAIL unlock state=%0d unlocked=%b count=%0d want 4 1 0", state, unlocked, digit_count);
    end
    program_sw = 1'b0;
    ir_low = 0;
    press(5'b10000, -1, 0);
    n_checks++;
    if (state !== 3'd2 || ir_low != 1 || unlocked !== 1'b0) begin
      n_fail++;
      $display("FAIL relock state=%0d ir_low=%0d unlocked=%b want 2 1 0", state, ir_low, unlocked);
    end
  endtask

  task automatic test_bounce();
    exp_q.push_back('{1, 1});
    for (int i = 0; i < 10; i++) begin
      digit_key_n[1] = ~digit_key_n[1];
      repeat (2) tick();
    end
    digit_key_n = 4'b1101;
    repeat (10) tick();
    digit_key_n = 4'hf;
    repeat (12) tick();
    press(5'b01001, 1, 0);
    n_checks++;
    if (digit_count !== 3'd2 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bounce_count count=%0d pending=%0d want 2 0", digit_count, exp_q.size());
    end
    correct_password = 1'b1;
    press(5'b10000, 2, 0);
    n_checks++;
    if (state !== 3'd4) begin
      n_fail++;
      $display("FAIL bounce_open got=%0d want=4", state);
    end
  endtask

  task automatic test_reprogram();
    program_sw = 1'b1;
    cr_low = 0;
    press(5'b10000, -1, 0);
    program_sw = 1'b0;
    n_checks++;
    if (cr_low != 4 || state !== 3'd1) begin
      n_fail++;
      $display("FAIL reprogram cr_low=%0d state=%0d want 4 1", cr_low, state);
    end
    press(5'b10000, -1, 0);
    n_checks++;
    if (state !== 3'd1) begin
      n_fail++;
      $display("FAIL empty_enter got=%0d want=1", state);
    end
    press(5'b00001, 0, 0);
    press(5'b00010, 0, 1);
    press(5'b00100, 0, 2);
    press(5'b01000, 0, 3);
    press(5'b00010, -1, 0);
    n_checks++;
    if (digit_count !== 3'd4 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL max_len count=%0d pending=%0d want 4 0", digit_count, exp_q.size());
    end
    press(5'b10000, -1, 0);
    n_checks++;
    if (state !== 3'd2) begin
      n_fail++;
      $display("FAIL reprogram_lock got=%0d want=2", state);
    end
  endtask

  task automatic test_alarm();
    int want [5] = '{5, 2, 5, 2, 6};
    correct_password = 1'b0;
    incorrect_password = 1'b1;
    press(5'b00010, 1, 1);
    press(5'b00010, 1, 1);
    press(5'b10000, 2, 0);
    n_checks++;
    if (state !== 3'(want[0])) begin
      n_fail++;
      $display("FAIL alarm_seq0 got=%0d want=%0d", state, want[0]);
    end
    press(5'b10000, -1, 0);
    n_checks++;
    if (state !== 3'(want[1])) begin
      n_fail++;
      $display("FAIL alarm_seq1 got=%0d want=%0d", state, want[1]);
    end
    incorrect_password = 1'b0;
    press(5'b10000, 2, 0);
    n_checks++;
    if (state !== 3'(want[2])) begin
      n_fail++;
      $display("FAIL alarm_seq2 got=%0d want=%0d", state, want[2]);
    end
    press(5'b00001, -1, 0);
    press(5'b10000, -1, 0);
    n_checks++;
    if (state !== 3'(want[3])) begin
      n_fail++;
      $display("FAIL alarm_seq3 got=%0d want=%0d", state, want[3]);
    end
    incorrect_password = 1'b1;
    press(5'b01000, 1, 3);
    press(5'b10000, 2, 0);
    n_checks++;
    if (state !== 3'(want[4]) || alarm !== 1'b1 || unlocked !== 1'b0) begin
      n_fail++;
      $display("FAIL alarm_seq4 state=%0d alarm=%b unlocked=%b want %0d 1 0", state, alarm, unlocked, want[4]);
    end
    press(5'b00001, -1, 0);
    press(5'b10000, -1, 0);
    n_checks++;
    if (state !== 3'd6 || alarm !== 1'b1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL alarm_hold state=%0d alarm=%b pending=%0d want 6 1 0", state, alarm, exp_q.size());
    end
  endtask

  task automatic test_async_reset();
    int t;
    system_reset = 1'b0;
    repeat (2) tick();
    system_reset = 1'b1;
    repeat (10) tick();
    n_checks++;
    if (state !== 3'd1 || alarm !== 1'b0) begin
      n_fail++;
      $display("FAIL alarm_exit state=%0d alarm=%b want 1 0", state, alarm);
    end
    exp_q.push_back('{0, 2});
    digit_key_n = 4'b1011;
    t = 0;
    while (store_value !== 1'b1 && t < 30) begin
      tick();
      t++;
    end
    n_checks++;
    if (store_value !== 1'b1) begin
      n_fail++;
      $display("FAIL strobe_timeout got store_value=%b want 1 within 30 cycles", store_value);
    end
    system_reset = 1'b0;
    #1;
    n_checks++;
    if (store_value !== 1'b0 || state !== 3'd0 || checker_reset !== 1'b0 || bits !== 2'd0) begin
      n_fail++;
      $display("FAIL midpulse_reset store=%b state=%0d cr=%b bits=%0d want 0 0 0 0",
               store_value, state, checker_reset, bits);
    end
    digit_key_n = 4'hf;
    repeat (3) tick();
    system_reset = 1'b1;
    repeat (10) tick();
    n_checks++;
    if (state !== 3'd1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL post_reset state=%0d pending=%0d want 1 0", state, exp_q.size());
    end
  endtask

  initial begin
    system_reset       = 1'b1;
    digit_key_n        = 4'hf;
    enter_key_n        = 1'b1;
    program_sw         = 1'b0;
    correct_password   = 1'b0;
    incorrect_password = 1'b0;
    #2;
    test_reset();
    test_program();
    test_unlock();
    test_bounce();
    test_reprogram();
    test_alarm();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lock_controller.md
Name: lock_controller

Overview:
- Front-end controller for the keypad lock. Sits directly upstream of the code checker.
- Synchronises and debounces the raw active-low push buttons and encodes the pressed digit key onto the 2-bit `bits` bus.
- Sequences program/unlock/compare operations through an FSM, generating the checker's `store_value`, `input_value` and `compare` strobes and its two active-low resets.
- Samples the checker's correct/incorrect result, tracks failed attempts and drives the unlock/alarm indicators.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable cycles required before a key level is accepted (5 ms at 50 MHz).
- MAX_LEN, 4: maximum digits per password or entry; must be ≤ 4.
- MAX_ATTEMPTS, 3: consecutive failed compares that trigger the alarm.
- STROBE_CYCLES, 2: high time of `store_value` / `input_value` / `compare` pulses.
- RST_CYCLES, 4: low time of `checker_reset`.

Ports:
- clk  in  1  system clock
- system_reset  in  1  asynchronous, active-low reset
- digit_key_n  in  4  raw active-low digit keys; index = digit value 0..3
- enter_key_n  in  1  raw active-low enter key
- program_sw  in  1  level switch, 1 = re-program request
- correct_password  in  1  from code checker
- incorrect_password  in  1  from code checker
- bits  out  2  digit value presented to code checker
- store_value  out  1  strobe: store digit in system password
- input_value  out  1  strobe: store digit in entered code
- compare  out  1  strobe: start compare
- input_reset  out  1  active-low clear of entered code
- checker_reset  out  1  active-low clear of whole checker
- unlocked  out  1  lock open indicator
- alarm  out  1  alarm indicator
- state  out  3  FSM state encoding, for display
- digit_count  out  3  digits accepted in current entry

Behaviour:
- Reset (async, `system_reset`=0):
  - state=INIT; `bits`=0; all strobes=0; `unlocked`=0; `alarm`=0; `digit_count`=0; attempts=0.
  - `input_reset`=0 and `checker_reset`=0 (asserted).
  - Strobes drop immediately on reset, including mid-pulse.
- Input conditioning:
  - Each of the 5 keys passes through a 2-FF synchroniser, then its own debounce counter.
  - The debounced level changes only after the synchronised level differs from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
  - Press event = debounced 1→0 transition, one cycle wide. Release generates no event.
- Same-cycle conflicts:
  - Several digit events: lowest index accepted, rest dropped.
  - Digit and enter together: digit handled, enter dropped.
- Digit strobe timing, for an event accepted at cycle N:
  - `bits` = digit at N+1, held until the next accepted digit.
  - Strobe high for cycles N+2 .. N+1+STROBE_CYCLES.
  - Any key event arriving while a strobe or compare sequence is in progress is dropped.
- State encoding: INIT=0, PROGRAM=1, LOCKED=2, COMPARE=3, OPEN=4, FAIL=5, ALARM=6.
- INIT: hold `checker_reset`/`input_reset` low for RST_CYCLES cycles after reset release, release both, go to PROGRAM.
- PROGRAM:
  - Digit with `digit_count` < MAX_LEN → `store_value` strobe, `digit_count`++. Further digits are ignored.
  - Enter with `digit_count`=0 → ignored.
  - Enter with `digit_count`≥1 → `input_reset` low 1 cycle, `digit_count`=0, go to LOCKED.
- LOCKED:
  - Digit with `digit_count` < MAX_LEN → `input_value` strobe, `digit_count`++. Excess digits are ignored.
  - Enter → COMPARE, including when `digit_count`=0.
  - `program_sw` is ignored.
- COMPARE sequence:
  - `compare` high STROBE_CYCLES cycles, then low 2 cycles.
  - On the third low cycle, sample the result.
  - `correct_password`=1 → attempts=0, go to OPEN.
  - Otherwise (incorrect, or neither flag high) → attempts++. Go to ALARM if attempts = MAX_ATTEMPTS, else FAIL.
  - `digit_count`=0 on exit.
- OPEN:
  - `unlocked`=1.
  - Enter with `program_sw`=1 → `checker_reset` low RST_CYCLES cycles, go to PROGRAM.
  - Enter with `program_sw`=0 → `input_reset` low 1 cycle, go to LOCKED.
- FAIL: enter → `input_reset` low 1 cycle, go to LOCKED. Digits are ignored.
- ALARM: `alarm`=1. All keys are ignored; only `system_reset` exits.
- Attempt counter saturates at MAX_ATTEMPTS. `state` and `digit_count` are registered outputs.

Test Plan (bench uses DEBOUNCE_CYCLES=4):
- Reset release → `checker_reset`=`input_reset`=0 for 4 cycles, then 1; `state`=1; all strobes 0.
- PROGRAM, press keys 2,1,3 then enter:
  - 3 `store_value` pulses, each 2 cycles, with `bits`=2,1,3 stable one cycle before each rising edge.
  - `input_reset` low 1 cycle; `state`=2.
- LOCKED, enter 2,1,3, enter, checker returns `correct_password`=1:
  - 3 `input_value` pulses, then one 2-cycle `compare` pulse.
  - `state`=4, `unlocked`=1.
- Three wrong entries with `incorrect_password`=1: `state` goes 5, 2, 5, 2, then 6; `alarm`=1; further keys produce no strobes until reset.
- Bounce: key 1 toggled every 2 cycles for 20 cycles, then held low → exactly one `input_value` pulse with `bits`=1. Keys 0 and 3 pressed in the same cycle → one pulse with `bits`=0.
- OPEN with `program_sw`=1, press enter → `checker_reset` low 4 cycles, `state`=1. Five digits pressed → only 4 `store_value` pulses, `digit_count`=4.
